// File: rtl/vector_sweep_checker_pkg.sv
// rtl/vector_sweep_checker_pkg.sv - state encodings and defaults shared by the sweep checker
package vector_sweep_checker_pkg;

  typedef enum logic [1:0] {
    VS_IDLE  = 2'd0,
    VS_DRIVE = 2'd1,
    VS_DONE  = 2'd2
  } vs_state_e;

  localparam int VS_DEFAULT_HOLD = 20;

endpackage

// File: rtl/vector_sweep_checker_sweep_timer.sv
// rtl/vector_sweep_checker_sweep_timer.sv - HOLD-cycle counter with clear and terminal count
module sweep_timer
  import vector_sweep_checker_pkg::*;
#(
  parameter int HOLD = VS_DEFAULT_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;

  logic [CW-1:0] count;

  assign tc = en && (count == CW'(HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vector_sweep_checker.sv
// rtl/vector_sweep_checker.sv - exhaustive input sweep with truth-table response checking
module vector_sweep_checker
  import vector_sweep_checker_pkg::*;
#(
  parameter int                N_IN  = 4,
  parameter int                HOLD  = VS_DEFAULT_HOLD,
  parameter logic [2**N_IN-1:0] TRUTH = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] abcd,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_vld
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  vs_state_e state, next_state;
  logic      accept;
  logic      sample;
  logic      mismatch;
  logic      tc;

  // start is only honoured outside a sweep; a running sweep cannot be restarted
  assign accept   = start && (state != VS_DRIVE);
  assign sample   = (state == VS_DRIVE) && tc;
  assign mismatch = (f_in != TRUTH[abcd]);
  assign busy     = (state == VS_DRIVE);
  assign done     = (state == VS_DONE);

  sweep_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == VS_DRIVE),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= VS_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      VS_IDLE, VS_DONE: if (start) next_state = VS_DRIVE;
      VS_DRIVE:         if (sample && (abcd == LAST_VEC)) next_state = VS_DONE;
      default:          next_state = VS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abcd          <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
    end else if (accept) begin
      abcd          <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        err_count <= err_count + (N_IN+1)'(1);
        if (!first_err_vld) begin
          first_err_vec <= abcd;
          first_err_vld <= 1'b1;
        end
      end
      // the final vector's own mismatch must count toward pass
      if (abcd != LAST_VEC) begin
        abcd <= abcd + N_IN'(1);
      end else begin
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_vector_sweep_checker.sv
// tb/tb_vector_sweep_checker.sv - randomized self-checking bench for vector_sweep_checker
module tb_vector_sweep_checker;

  localparam int HOLD = 20;
  localparam int NVEC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       f_a, f_b;
  logic [3:0] abcd_a, abcd_b, fev_a, fev_b;
  logic [4:0] err_a, err_b;
  logic       busy_a, done_a, pass_a, fvl_a;
  logic       busy_b, done_b, pass_b, fvl_b;

  int tests = 0;
  int fails = 0;

  int          mode_a = 0;
  int          mode_b = 0;
  int          dly = 1;
  logic [15:0] rand_tab = 16'h0;
  logic [15:0] truth_a_v = 16'h6996;
  logic [15:0] truth_b_v = 16'h8001;
  logic [3:0]  hist [32];

  always #5 clk = ~clk;

  vector_sweep_checker #(.N_IN(4), .HOLD(HOLD), .TRUTH(16'h6996)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vec(fev_a), .first_err_vld(fvl_a)
  );

  vector_sweep_checker #(.N_IN(4), .HOLD(HOLD), .TRUTH(16'h8001)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vec(fev_b), .first_err_vld(fvl_b)
  );

  always @(posedge clk) begin
    for (int i = 31; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= abcd_a;
  end

  // functions under test: parity, stuck-at-0, random table, delayed parity
  always_comb begin
    f_a = 1'b0;
    case (mode_a)
      0: f_a = ^abcd_a;
      2: f_a = rand_tab[abcd_a];
      3: f_a = ^hist[dly-1];
      default: f_a = 1'b0;
    endcase
    f_b = (mode_b == 1) ? truth_b_v[abcd_b] : 1'b0;
  end

  function automatic void model(input logic [15:0] diff, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 0; i < NVEC; i++) begin
      if (diff[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endfunction

  task automatic do_sweep(input bit sel, input int pulse_at, output int lat,
                          output bit seq_ok, output bit clr_ok);
    logic [3:0] av;
    logic [4:0] ev;
    logic       bz, dn, ps, vl;
    lat = -1;
    seq_ok = 1'b1;
    clr_ok = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int n = 0; n <= 400; n++) begin
      av = sel ? abcd_b : abcd_a;
      ev = sel ? err_b : err_a;
      bz = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      ps = sel ? pass_b : pass_a;
      vl = sel ? fvl_b : fvl_a;
      if (n == 0) clr_ok = (ev == 5'd0) && !vl && !dn && !ps && bz && (av == 4'd0);
      if (dn) begin
        lat = n;
        break;
      end
      if (!bz || av != 4'(n / HOLD)) seq_ok = 1'b0;
      if (sel) start_b = (n == pulse_at); else start_a = (n == pulse_at);
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({abcd_a, busy_a, done_a, pass_a, err_a, fev_a, fvl_a} !== 17'd0) begin
      fails++;
      $display("FAIL reset_a: got %h want 0", {abcd_a, busy_a, done_a, pass_a, err_a, fev_a, fvl_a});
    end
    tests++;
    if ({abcd_b, busy_b, done_b, pass_b, err_b, fev_b, fvl_b} !== 17'd0) begin
      fails++;
      $display("FAIL reset_b: got %h want 0", {abcd_b, busy_b, done_b, pass_b, err_b, fev_b, fvl_b});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_golden();
    int lat; bit sok, cok;
    mode_a = 0;
    do_sweep(1'b0, -1, lat, sok, cok);
    tests++; if (lat != NVEC * HOLD) begin fails++; $display("FAIL golden_latency: got %0d want %0d", lat, NVEC * HOLD); end
    tests++; if (!sok) begin fails++; $display("FAIL golden_sequence: got bad abcd/busy want 0..15 x %0d", HOLD); end
    tests++; if (pass_a !== 1'b1) begin fails++; $display("FAIL golden_pass: got %b want 1", pass_a); end
    tests++; if (err_a !== 5'd0) begin fails++; $display("FAIL golden_err: got %0d want 0", err_a); end
    tests++; if (fvl_a !== 1'b0) begin fails++; $display("FAIL golden_vld: got %b want 0", fvl_a); end
    tests++; if ({busy_a, abcd_a} !== 5'h0f) begin fails++; $display("FAIL golden_final: got busy/abcd %h want 0f", {busy_a, abcd_a}); end
  endtask

  task automatic test_stuck();
    int lat, cnt, first; bit sok, cok;
    mode_b = 0;
    model(truth_b_v, cnt, first);
    do_sweep(1'b1, -1, lat, sok, cok);
    tests++; if (lat != NVEC * HOLD) begin fails++; $display("FAIL stuck_latency: got %0d want %0d", lat, NVEC * HOLD); end
    tests++; if (err_b !== 5'(cnt)) begin fails++; $display("FAIL stuck_err: got %0d want %0d", err_b, cnt); end
    tests++; if (fvl_b !== 1'b1 || fev_b !== 4'(first)) begin fails++; $display("FAIL stuck_first: got vld %b vec %0d want 1 %0d", fvl_b, fev_b, first); end
    tests++; if (pass_b !== 1'b0) begin fails++; $display("FAIL stuck_pass: got %b want 0", pass_b); end
  endtask

  task automatic test_restart();
    int lat; bit sok, cok;
    mode_b = 1;
    do_sweep(1'b1, -1, lat, sok, cok);
    tests++; if (!cok) begin fails++; $display("FAIL restart_clear: got counts/done not cleared at accept want cleared"); end
    tests++; if (!sok) begin fails++; $display("FAIL restart_sequence: got bad abcd/busy want 0..15"); end
    tests++; if (lat != NVEC * HOLD) begin fails++; $display("FAIL restart_latency: got %0d want %0d", lat, NVEC * HOLD); end
    tests++; if ({pass_b, err_b, fvl_b} !== 7'b1_00000_0) begin fails++; $display("FAIL restart_result: got pass %b err %0d vld %b want 1 0 0", pass_b, err_b, fvl_b); end
  endtask

  task automatic test_random();
    int lat, cnt, first; bit sok, cok;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) rand_tab = truth_a_v ^ (16'h1 << $urandom_range(15));
      else rand_tab = 16'($urandom);
      mode_a = 2;
      model(rand_tab ^ truth_a_v, cnt, first);
      do_sweep(1'b0, -1, lat, sok, cok);
      tests++; if (lat != NVEC * HOLD) begin fails++; $display("FAIL random_latency[%0d]: got %0d want %0d", it, lat, NVEC * HOLD); end
      tests++; if (err_a !== 5'(cnt)) begin fails++; $display("FAIL random_err[%0d]: tab %h got %0d want %0d", it, rand_tab, err_a, cnt); end
      tests++; if (fvl_a !== (first >= 0)) begin fails++; $display("FAIL random_vld[%0d]: got %b want %b", it, fvl_a, first >= 0); end
      if (first >= 0) begin
        tests++; if (fev_a !== 4'(first)) begin fails++; $display("FAIL random_first[%0d]: got %0d want %0d", it, fev_a, first); end
      end
      tests++; if (pass_a !== (cnt == 0)) begin fails++; $display("FAIL random_pass[%0d]: got %b want %b", it, pass_a, cnt == 0); end
    end
  endtask

  task automatic test_late_settle();
    int lat, cnt, first, m; bit sok, cok;
    logic [3:0]  a_before;
    logic [15:0] seen;
    int d_list [2] = '{18, 20};
    for (int j = 0; j < 2; j++) begin
      dly = d_list[j];
      mode_a = 3;
      repeat (25) @(negedge clk);
      a_before = abcd_a;
      // vector k is sampled at the end of cycle 20k+19; the DUT sees abcd from dly cycles earlier
      for (int k = 0; k < NVEC; k++) begin
        m = k * HOLD + HOLD - 1 - dly;
        seen[k] = ^((m < 0) ? a_before : 4'(m / HOLD));
      end
      model(seen ^ truth_a_v, cnt, first);
      do_sweep(1'b0, -1, lat, sok, cok);
      tests++; if (err_a !== 5'(cnt)) begin fails++; $display("FAIL late_err[d=%0d]: got %0d want %0d", dly, err_a, cnt); end
      tests++; if (pass_a !== (cnt == 0)) begin fails++; $display("FAIL late_pass[d=%0d]: got %b want %b", dly, pass_a, cnt == 0); end
    end
    tests++; if (err_a == 5'd0) begin fails++; $display("FAIL late_unsettled: got err 0 want >0"); end
  endtask

  task automatic test_start_during();
    int lat; bit sok, cok;
    mode_a = 0;
    do_sweep(1'b0, 7 * HOLD + 5, lat, sok, cok);
    tests++; if (lat != NVEC * HOLD) begin fails++; $display("FAIL midstart_latency: got %0d want %0d", lat, NVEC * HOLD); end
    tests++; if (!sok) begin fails++; $display("FAIL midstart_sequence: got disturbed abcd want 0..15"); end
    tests++; if ({pass_a, err_a} !== 6'b1_00000) begin fails++; $display("FAIL midstart_result: got pass %b err %0d want 1 0", pass_a, err_a); end
  endtask

  task automatic test_reset_mid();
    int lat; bit sok, cok;
    mode_a = 0;
    mode_b = 0;
    @(negedge clk); start_a = 1'b1; start_b = 1'b1;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    repeat (5 * HOLD + 3) @(negedge clk);
    tests++; if (abcd_a !== 4'd5) begin fails++; $display("FAIL midreset_pre: got abcd %0d want 5", abcd_a); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({abcd_a, busy_a, done_a, pass_a, err_a, fev_a, fvl_a} !== 17'd0) begin
      fails++;
      $display("FAIL midreset_async_a: got %h want 0", {abcd_a, busy_a, done_a, pass_a, err_a, fev_a, fvl_a});
    end
    tests++;
    if ({abcd_b, busy_b, err_b, fvl_b} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_async_b: got %h want 0", {abcd_b, busy_b, err_b, fvl_b});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({busy_a, abcd_a} !== 5'd0) begin fails++; $display("FAIL midreset_no_resume: got busy/abcd %h want 0", {busy_a, abcd_a}); end
    do_sweep(1'b0, -1, lat, sok, cok);
    tests++; if (!cok || !sok) begin fails++; $display("FAIL midreset_resweep: got clear %b seq %b want 1 1", cok, sok); end
    tests++; if (lat != NVEC * HOLD || pass_a !== 1'b1) begin fails++; $display("FAIL midreset_done: got lat %0d pass %b want %0d 1", lat, pass_a, NVEC * HOLD); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_restart();
    test_random();
    test_late_settle();
    test_start_during();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
